note_timer: RTL and testbench

//  Time base and note-duration counter for one channel. Divides i_clk into a

---
 rtl/note_timer.sv | 64 ++++++
 tb/tb_note_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/note_timer.sv
// Per-channel time base: divides i_clk into a tick strobe and counts down
// the ticks left in the current note, flagging note expiry on the tick.
module note_timer #(
    parameter int CLK_PER_TICK = 250000,
    parameter int DUR_WIDTH    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_duration_load,
    input  logic [DUR_WIDTH-1:0] i_duration,
    output logic                 o_tick_stb,
    output logic                 o_note_stb,
    output logic [DUR_WIDTH-1:0] o_remaining
);

    localparam int CNT_WIDTH = $clog2(CLK_PER_TICK);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLK_PER_TICK - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DUR_WIDTH-1:0] remaining_q, remaining_d;
    logic                 tick_stb_q, tick_stb_d;
    logic                 note_stb_q, note_stb_d;
    logic                 tick_edge;

    always_comb begin
        tick_edge   = i_enable && (cnt_q == CNT_LAST);
        cnt_d       = cnt_q;
        tick_stb_d  = tick_edge;
        note_stb_d  = tick_edge && (remaining_q == '0);
        remaining_d = remaining_q;

        if (i_enable) begin
            cnt_d = tick_edge ? '0 : cnt_q + CNT_WIDTH'(1);
        end

        // A load replaces the count outright; stored as D-1 so note_stb
        // lands D ticks after the tick that started this note.
        if (i_duration_load) begin
            remaining_d = (i_duration == '0) ? '0 : i_duration - DUR_WIDTH'(1);
        end else if (tick_edge && (remaining_q != '0)) begin
            remaining_d = remaining_q - DUR_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q       <= '0;
            remaining_q <= '0;
            tick_stb_q  <= 1'b0;
            note_stb_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            tick_stb_q  <= tick_stb_d;
            note_stb_q  <= note_stb_d;
        end
    end

    assign o_tick_stb  = tick_stb_q;
    assign o_note_stb  = note_stb_q;
    assign o_remaining = remaining_q;

endmodule

// File: tb/tb_note_timer.sv
// Bench for note_timer: directed vector table with hand-derived expectations,
// plus a cycle scoreboard fed by a behavioural model of ticks and durations.
module tb_note_timer;

    localparam int N  = 10;
    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_enable = 1'b0;
    logic          i_duration_load = 1'b0;
    logic [DW-1:0] i_duration = '0;
    logic          o_tick_stb;
    logic          o_note_stb;
    logic [DW-1:0] o_remaining;

    note_timer #(.CLK_PER_TICK(N), .DUR_WIDTH(DW)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_enable(i_enable),
        .i_duration_load(i_duration_load),
        .i_duration(i_duration),
        .o_tick_stb(o_tick_stb),
        .o_note_stb(o_note_stb),
        .o_remaining(o_remaining)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          tick;
        bit          note;
        logic [DW-1:0] rem;
    } exp_t;

    typedef struct {
        bit            rst;
        bit            en;
        bit            ld;
        logic [DW-1:0] dur;
        int            reps;
        bit            e_tick;
        bit            e_note;
        logic [DW-1:0] e_rem;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    // model state: enabled edges since reset, remaining ticks
    int m_ecnt = 0;
    int m_rem  = 0;

    function automatic vec_t mk(bit rst, bit en, bit ld, int dur, int reps,
                                bit et, bit en_, int er);
        vec_t v;
        v.rst = rst; v.en = en; v.ld = ld; v.dur = DW'(dur); v.reps = reps;
        v.e_tick = et; v.e_note = en_; v.e_rem = DW'(er);
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; model predicts the post-edge outputs, scoreboard compares.
    task automatic step(bit rst, bit en, bit ld, logic [DW-1:0] dur);
        exp_t e, got;
        bit tick;
        @(negedge i_clk);
        i_rst = rst; i_enable = en; i_duration_load = ld; i_duration = dur;
        if (rst) begin
            m_ecnt = 0; m_rem = 0;
            e.tick = 0; e.note = 0;
        end else begin
            tick = 0;
            if (en) begin
                m_ecnt++;
                tick = (m_ecnt % N) == 0;
            end
            e.tick = tick;
            e.note = tick && (m_rem == 0);
            if (ld) m_rem = (dur == 0) ? 0 : int'(dur) - 1;
            else if (tick && m_rem > 0) m_rem--;
        end
        e.rem = DW'(m_rem);
        sb_q.push_back(e);
        @(posedge i_clk);
        #1;
        got = sb_q.pop_front();
        check("sb_tick", int'(o_tick_stb), int'(got.tick));
        check("sb_note", int'(o_note_stb), int'(got.note));
        check("sb_rem",  int'(o_remaining), int'(got.rem));
    endtask

    initial begin
        int gap;
        int waited;
        bit seen;

        // reset
        vecs.push_back(mk(1,0,0,0,2,  0,0,0));
        // 1: free-running, every tick carries note_stb
        vecs.push_back(mk(0,1,0,0,9,  0,0,0));
        vecs.push_back(mk(0,1,0,0,1,  1,1,0));
        vecs.push_back(mk(0,1,0,0,9,  0,0,0));
        vecs.push_back(mk(0,1,0,0,1,  1,1,0));   // T0
        // 2: D=3 loaded two cycles after T0
        vecs.push_back(mk(0,1,0,0,1,  0,0,0));
        vecs.push_back(mk(0,1,1,3,1,  0,0,2));
        vecs.push_back(mk(0,1,0,0,7,  0,0,2));
        vecs.push_back(mk(0,1,0,0,1,  1,0,1));   // T1
        vecs.push_back(mk(0,1,0,0,9,  0,0,1));
        vecs.push_back(mk(0,1,0,0,1,  1,0,0));   // T2
        vecs.push_back(mk(0,1,0,0,9,  0,0,0));
        vecs.push_back(mk(0,1,0,0,1,  1,1,0));   // T3
        // 3: D=1 then D=0
        vecs.push_back(mk(0,1,1,1,1,  0,0,0));
        vecs.push_back(mk(0,1,0,0,8,  0,0,0));
        vecs.push_back(mk(0,1,0,0,1,  1,1,0));
        vecs.push_back(mk(0,1,1,0,1,  0,0,0));
        vecs.push_back(mk(0,1,0,0,8,  0,0,0));
        vecs.push_back(mk(0,1,0,0,1,  1,1,0));
        // 4: remaining=4, enable dropped 25 cycles mid-period
        vecs.push_back(mk(0,1,1,5,1,  0,0,4));
        vecs.push_back(mk(0,1,0,0,3,  0,0,4));
        vecs.push_back(mk(0,0,0,0,25, 0,0,4));
        vecs.push_back(mk(0,1,0,0,5,  0,0,4));
        vecs.push_back(mk(0,1,0,0,1,  1,0,3));
        // 5: run down to 0, then load D=5 on the tick edge
        vecs.push_back(mk(0,1,0,0,9,  0,0,3));
        vecs.push_back(mk(0,1,0,0,1,  1,0,2));
        vecs.push_back(mk(0,1,0,0,9,  0,0,2));
        vecs.push_back(mk(0,1,0,0,1,  1,0,1));
        vecs.push_back(mk(0,1,0,0,9,  0,0,1));
        vecs.push_back(mk(0,1,0,0,1,  1,0,0));
        vecs.push_back(mk(0,1,0,0,9,  0,0,0));
        vecs.push_back(mk(0,1,1,5,1,  1,1,4));
        // 6: reset with remaining=5, prescaler=6
        vecs.push_back(mk(0,1,1,6,1,  0,0,5));
        vecs.push_back(mk(0,1,0,0,5,  0,0,5));
        vecs.push_back(mk(1,1,0,0,1,  0,0,0));
        vecs.push_back(mk(0,1,0,0,9,  0,0,0));
        vecs.push_back(mk(0,1,0,0,1,  1,1,0));
        // load accepted while disabled
        vecs.push_back(mk(0,0,1,2,1,  0,0,1));
        vecs.push_back(mk(0,0,0,0,3,  0,0,1));

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++)
                step(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].dur);
            check($sformatf("vec%0d_tick", i), int'(o_tick_stb), int'(vecs[i].e_tick));
            check($sformatf("vec%0d_note", i), int'(o_note_stb), int'(vecs[i].e_note));
            check($sformatf("vec%0d_rem", i),  int'(o_remaining), int'(vecs[i].e_rem));
        end

        // tick spacing stretched by exactly the disabled window
        step(1, 0, 0, '0);
        seen = 0; waited = 0;
        while (!seen && waited < 40) begin
            step(0, 1, 0, '0);
            waited++;
            seen = o_tick_stb;
        end
        check("first_tick_latency", waited, N);
        gap = 0; seen = 0;
        while (!seen && gap < 80) begin
            step(0, (gap < 3 || gap >= 28), 0, '0);
            gap++;
            seen = o_tick_stb;
        end
        check("stretched_gap", gap, N + 25);

        // randomised run, scoreboard only
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) == 0),
                 DW'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
